// File: rtl/bb_arbiter.sv
// bb_arbiter: shares one BB black-box datapath between NUM_REQ requesters.
//
// A round-robin arbiter grants one requester at a time. The granted operand is
// registered onto io_bb_input and held for LATENCY cycles. The BB output is then
// captured and returned on a valid/ready response port, tagged with the requester
// index. Only one operation is in flight at a time.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   io_req_valid   per-requester request valid
//   io_req_ready   per-requester grant (at most one bit set, only in idle)
//   io_req_data    operands, requester i at [i*DATA_W +: DATA_W]
//   io_resp_valid  result available
//   io_resp_ready  consumer accepts result
//   io_resp_data   captured BB output
//   io_resp_id     index of the requester owning io_resp_data
//   io_bb_input    registered operand driving the BB input
//   io_bb_output   BB output
//   io_busy        high whenever an operation is in progress
module bb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_req_valid,
    output logic [NUM_REQ-1:0]        io_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
    output logic                      io_resp_valid,
    input  logic                      io_resp_ready,
    output logic [DATA_W-1:0]         io_resp_data,
    output logic [ID_W-1:0]           io_resp_id,
    output logic [DATA_W-1:0]         io_bb_input,
    input  logic [DATA_W-1:0]         io_bb_output,
    output logic                      io_busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bb_input_q, bb_input_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   next_ptr;
    logic              accept;

    // Round-robin search: first valid index at or above rr_ptr, wrapping to 0.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && io_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
        nxt = 32'(grant_id) + 1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end
        next_ptr = ID_W'(nxt);
    end

    // Reset gates the grant so that the ready bits read 0 while reset is held,
    // even though the state register already reads idle.
    assign accept = (state_q == StIdle) && grant_found && !reset;

    always_comb begin
        io_req_ready = '0;
        if (accept) begin
            io_req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        cnt_d       = cnt_q;
        bb_input_d  = bb_input_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    bb_input_d = io_req_data[grant_id*DATA_W +: DATA_W];
                    resp_id_d  = grant_id;
                    rr_ptr_d   = next_ptr;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = StWait;
                end
            end
            StWait: begin
                // Operand has been stable since the accept edge; sample once the
                // counter has run down.
                if (cnt_q == '0) begin
                    resp_data_d = io_bb_output;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (io_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            cnt_q       <= '0;
            bb_input_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            cnt_q       <= cnt_d;
            bb_input_q  <= bb_input_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign io_resp_valid = (state_q == StResp);
    assign io_busy       = (state_q != StIdle);
    assign io_resp_data  = resp_data_q;
    assign io_resp_id    = resp_id_q;
    assign io_bb_input   = bb_input_q;

endmodule
